// File: rtl/transformation_pkg.sv
// rtl/transformation_pkg.sv - shared state encoding, base addresses and result fitting
package transformation_pkg;

  typedef enum logic [2:0] {IDLE, W_REQ, W_WAIT, F_REQ, F_WAIT, DONE} state_t;

  localparam int unsigned DEFAULT_WEIGHT_BASE  = 'h000;
  localparam int unsigned DEFAULT_FEATURE_BASE = 'h200;

  // Clamp a full-width sum into a dpw-bit field (or pass it through for truncation);
  // the caller keeps the low dpw bits of the return value.
  function automatic logic [63:0] fit_result(input logic signed [63:0] acc, input int dpw,
                                             input logic sgn, input logic sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = sgn ? (64'sd1 <<< (dpw - 1)) - 64'sd1 : (64'sd1 <<< dpw) - 64'sd1;
    lo = sgn ? -(64'sd1 <<< (dpw - 1)) : 64'sd0;
    if (sat && acc > hi) return hi;
    if (sat && acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/dot_product_lane.sv
// rtl/dot_product_lane.sv - combinational full-width dot product of one feature row and one weight column
module dot_product_lane #(
  parameter int FEATURE_COLS = 96,
  parameter int DATA_WIDTH   = 5,
  parameter int ACC_WIDTH    = 18
) (
  input  logic [0:FEATURE_COLS-1][DATA_WIDTH-1:0] feature,
  input  logic [0:FEATURE_COLS-1][DATA_WIDTH-1:0] weight,
  input  logic                                    signed_mode,
  output logic signed [ACC_WIDTH-1:0]             sum
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH + 2;

  logic signed [DATA_WIDTH:0]   fe;
  logic signed [DATA_WIDTH:0]   we;
  logic signed [PROD_WIDTH-1:0] prod;

  // One extra bit per element makes the unsigned case a non-negative signed value.
  always_comb begin
    sum  = '0;
    fe   = '0;
    we   = '0;
    prod = '0;
    for (int i = 0; i < FEATURE_COLS; i++) begin
      fe   = {signed_mode & feature[i][DATA_WIDTH-1], feature[i]};
      we   = {signed_mode & weight[i][DATA_WIDTH-1], weight[i]};
      prod = PROD_WIDTH'(fe) * PROD_WIDTH'(we);
      sum  = sum + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/transformation_engine.sv
// rtl/transformation_engine.sv - FM x WM engine: weight scratchpad load, then one feature row per request
module transformation_engine
  import transformation_pkg::*;
#(
  parameter int                          FEATURE_COLS   = 96,
  parameter int                          FEATURE_ROWS   = 6,
  parameter int                          WEIGHT_COLS    = 3,
  parameter int                          DATA_WIDTH     = 5,
  parameter int                          DOT_PROD_WIDTH = 16,
  parameter int                          ADDRESS_WIDTH  = 13,
  parameter logic [ADDRESS_WIDTH-1:0]    WEIGHT_BASE    = ADDRESS_WIDTH'(DEFAULT_WEIGHT_BASE),
  parameter logic [ADDRESS_WIDTH-1:0]    FEATURE_BASE   = ADDRESS_WIDTH'(DEFAULT_FEATURE_BASE),
  parameter int                          SATURATE       = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      signed_mode,
  input  logic                                      abort,
  input  logic [0:FEATURE_COLS-1][DATA_WIDTH-1:0]   data_in,
  input  logic                                      mem_valid,
  input  logic [$clog2(FEATURE_ROWS)-1:0]           read_row,
  output logic [ADDRESS_WIDTH-1:0]                  read_address,
  output logic                                      enable_read,
  output logic                                      busy,
  output logic                                      done,
  output logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] fm_wm_row_out
);

  localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(FEATURE_COLS) + 1;
  localparam int WCNT_W    = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
  localparam int FCNT_W    = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;

  state_t                                             state_q, state_d;
  logic [WCNT_W-1:0]                                  wcnt_q;
  logic [FCNT_W-1:0]                                  fcnt_q;
  logic                                               sgn_q;
  logic [ADDRESS_WIDTH-1:0]                           addr_q;
  logic [0:WEIGHT_COLS-1][0:FEATURE_COLS-1][DATA_WIDTH-1:0] weights_q;
  logic [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] results_q;
  logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]         lane_res;

  logic last_w, last_f;
  assign last_w = (wcnt_q == WCNT_W'(WEIGHT_COLS - 1));
  assign last_f = (fcnt_q == FCNT_W'(FEATURE_ROWS - 1));

  for (genvar c = 0; c < WEIGHT_COLS; c++) begin : g_lane
    logic signed [ACC_WIDTH-1:0] lane_sum;
    dot_product_lane #(
      .FEATURE_COLS(FEATURE_COLS),
      .DATA_WIDTH  (DATA_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH)
    ) u_lane (
      .feature    (data_in),
      .weight     (weights_q[c]),
      .signed_mode(sgn_q),
      .sum        (lane_sum)
    );
    assign lane_res[c] = DOT_PROD_WIDTH'(fit_result(64'(lane_sum), DOT_PROD_WIDTH, sgn_q, SATURATE != 0));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = W_REQ;
      W_REQ:   state_d = W_WAIT;
      W_WAIT:  if (mem_valid) state_d = last_w ? F_REQ : W_REQ;
      F_REQ:   state_d = F_WAIT;
      F_WAIT:  if (mem_valid) state_d = last_f ? DONE : F_REQ;
      DONE:    if (start) state_d = W_REQ;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Address is live only in the request states; elsewhere it replays the last issued value.
  always_comb begin
    read_address = addr_q;
    if (state_q == W_REQ) read_address = WEIGHT_BASE + ADDRESS_WIDTH'(wcnt_q);
    if (state_q == F_REQ) read_address = FEATURE_BASE + ADDRESS_WIDTH'(fcnt_q);
  end

  assign enable_read   = (state_q == W_REQ) || (state_q == F_REQ);
  assign busy          = (state_q != IDLE) && (state_q != DONE);
  assign done          = (state_q == DONE);
  assign fm_wm_row_out = (int'(read_row) < FEATURE_ROWS) ? results_q[read_row] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      fcnt_q    <= '0;
      sgn_q     <= 1'b0;
      addr_q    <= WEIGHT_BASE;
      weights_q <= '0;
      results_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= read_address;
      if (abort) begin
        wcnt_q <= '0;
        fcnt_q <= '0;
      end else begin
        case (state_q)
          IDLE, DONE: if (start) begin
            sgn_q  <= signed_mode;
            wcnt_q <= '0;
            fcnt_q <= '0;
          end
          W_WAIT: if (mem_valid) begin
            weights_q[wcnt_q] <= data_in;
            wcnt_q            <= last_w ? '0 : wcnt_q + 1'b1;
          end
          F_WAIT: if (mem_valid) begin
            results_q[fcnt_q] <= lane_res;
            if (!last_f) fcnt_q <= fcnt_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
